// File: rtl/fetch_stage.sv
// Instruction-fetch stage: issues in-order word fetches, queues returned words with their PCs,
// and flushes the queue and discards in-flight responses on a control-flow redirect.
`timescale 1ns/1ps
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned DEPTH    = 2
) (
   input  logic        clk,
   input  logic        clr,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        inst_valid,
   input  logic        id_ready,
   output logic [31:0] Instruction,
   output logic [31:0] PCout
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

   entry_t           q_q   [DEPTH];
   entry_t           q_d   [DEPTH];
   logic [31:0]      trk_q [DEPTH];
   logic [31:0]      trk_d [DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W-1:0] trk_wr_q, trk_wr_d, trk_rd_q, trk_rd_d;
   logic [CNT_W-1:0] count_q, count_d, out_q, out_d, drop_q, drop_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [CNT_W:0]   credit_used;
   logic             req_fire, push, pop;
   logic             unused_redirect_lsb;

   // Credit rule: every outstanding request owns a queue slot, so the queue never overflows.
   assign credit_used    = {1'b0, count_q} + {1'b0, out_q};
   assign imem_req_valid = !clr && !redirect_valid && (credit_used < DEPTH_C);
   assign imem_req_addr  = fetch_pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign inst_valid  = (count_q != '0);
   assign Instruction = q_q[head_q].instr;
   assign PCout       = q_q[head_q].pc;

   assign pop  = inst_valid && id_ready && !redirect_valid;
   assign push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      q_d        = q_q;
      trk_d      = trk_q;
      head_d     = head_q;
      tail_d     = tail_q;
      trk_wr_d   = trk_wr_q;
      trk_rd_d   = trk_rd_q;
      count_d    = count_q + CNT_W'(push) - CNT_W'(pop);
      out_d      = out_q + CNT_W'(req_fire) - CNT_W'(imem_rsp_valid);
      drop_d     = drop_q;

      if (req_fire) begin
         fetch_pc_d      = fetch_pc_q + 32'd4;
         trk_d[trk_wr_q] = fetch_pc_q;
         trk_wr_d        = trk_wr_q + PTR_W'(1);
      end

      // The PC tracker advances on every response, including discarded ones.
      if (imem_rsp_valid) begin
         trk_rd_d = trk_rd_q + PTR_W'(1);
         if (drop_q != '0) begin
            drop_d = drop_q - CNT_W'(1);
         end
      end

      if (push) begin
         q_d[tail_q] = '{pc: trk_q[trk_rd_q], instr: imem_rsp_data};
         tail_d      = tail_q + PTR_W'(1);
      end

      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end

      // Everything still in flight after this edge belongs to the old path.
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         drop_d     = out_q - CNT_W'(imem_rsp_valid);
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         fetch_pc_q <= RESET_PC;
         q_q        <= '{default: '0};
         trk_q      <= '{default: '0};
         head_q     <= '0;
         tail_q     <= '0;
         trk_wr_q   <= '0;
         trk_rd_q   <= '0;
         count_q    <= '0;
         out_q      <= '0;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         q_q        <= q_d;
         trk_q      <= trk_d;
         head_q     <= head_d;
         tail_q     <= tail_d;
         trk_wr_q   <= trk_wr_d;
         trk_rd_q   <= trk_rd_d;
         count_q    <= count_d;
         out_q      <= out_d;
         drop_q     <= drop_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: queue-based reference model checked every cycle, plus directed scenarios
// with hand-computed request/delivery sequences.
`timescale 1ns/1ps
module tb_fetch_stage;

   localparam int unsigned DEPTH = 2;
   localparam logic [31:0] XOR_K = 32'hA5A5_0000;

   logic        clk = 1'b0;
   logic        clr;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid, id_ready;
   logic [31:0] Instruction, PCout;

   logic        w_req_valid, w_rsp_valid, w_inst_valid;
   logic [31:0] w_req_addr, w_rsp_data, w_instr, w_pc;

   always #5 clk = ~clk;

   fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) u_dut (
      .clk(clk), .clr(clr),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .inst_valid(inst_valid), .id_ready(id_ready), .Instruction(Instruction), .PCout(PCout)
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) u_wrap (
      .clk(clk), .clr(clr),
      .imem_req_valid(w_req_valid), .imem_req_ready(1'b1), .imem_req_addr(w_req_addr),
      .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
      .redirect_valid(1'b0), .redirect_pc(32'h0),
      .inst_valid(w_inst_valid), .id_ready(1'b1), .Instruction(w_instr), .PCout(w_pc)
   );

   typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
   typedef struct { logic [31:0] pc; bit drop; } req_t;
   typedef struct { logic [31:0] addr; int unsigned due; } mem_t;

   ent_t        m_buf[$];
   req_t        m_infl[$];
   logic [31:0] m_pc;
   mem_t        mem_q[$];
   int unsigned cyc = 0;
   int unsigned lat = 1;
   logic [31:0] acc_log[$];
   ent_t        del_log[$];
   logic [31:0] w_acc[$];
   logic [31:0] w_del[$];
   logic        w_fire_s = 1'b0;
   logic [31:0] w_addr_s = 32'h0;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          armed = 1'b0;
   logic        ev, eiv, do_pop;
   req_t        e;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Reference model: queues of buffered words and in-flight requests tagged for discard.
   always @(negedge clk) begin
      ev  = !clr && !redirect_valid && (m_buf.size() + m_infl.size() < DEPTH);
      eiv = (m_buf.size() != 0);
      if (armed) begin
         chk("imem_req_valid", imem_req_valid, ev);
         if (ev) chk("imem_req_addr", imem_req_addr, m_pc);
         chk("inst_valid", inst_valid, eiv);
         if (eiv) begin
            chk("Instruction", Instruction, m_buf[0].instr);
            chk("PCout", PCout, m_buf[0].pc);
         end
      end
      if (!clr && imem_req_valid && imem_req_ready) begin
         acc_log.push_back(imem_req_addr);
         mem_q.push_back('{addr: imem_req_addr, due: cyc + lat});
      end
      if (!clr && !redirect_valid && inst_valid && id_ready)
         del_log.push_back('{pc: PCout, instr: Instruction});
      if (clr) begin
         m_pc = 32'h0;
         m_buf.delete();
         m_infl.delete();
         armed = 1'b1;
      end else begin
         do_pop = eiv && id_ready && !redirect_valid;
         e = '{pc: 32'h0, drop: 1'b1};
         if (imem_rsp_valid) begin
            chk("rsp_has_request", 32'(m_infl.size() != 0), 32'd1);
            if (m_infl.size() != 0) begin
               e = m_infl[0];
               m_infl.delete(0);
            end
         end
         if (redirect_valid) begin
            m_buf.delete();
            foreach (m_infl[i]) m_infl[i].drop = 1'b1;
            m_pc = redirect_pc & ~32'h3;
         end else begin
            if (do_pop) m_buf.delete(0);
            if (imem_rsp_valid && !e.drop) m_buf.push_back('{pc: e.pc, instr: imem_rsp_data});
            if (ev && imem_req_ready) begin
               m_infl.push_back('{pc: m_pc, drop: 1'b0});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      if (!clr && w_req_valid) w_acc.push_back(w_req_addr);
      if (!clr && w_inst_valid) w_del.push_back(w_pc);
      w_fire_s = !clr && w_req_valid;
      w_addr_s = w_req_addr;
   end

   // Instruction memory: in-order responses 'lat' cycles after acceptance, word = addr ^ XOR_K.
   always @(posedge clk) begin
      cyc++;
      #2;
      if (clr) begin
         mem_q.delete();
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'h0;
      end else if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_q[0].addr ^ XOR_K;
         mem_q.delete(0);
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
      w_rsp_valid = !clr && w_fire_s;
      w_rsp_data  = w_addr_s ^ XOR_K;
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic clear_logs();
      acc_log.delete();
      del_log.delete();
      w_acc.delete();
      w_del.delete();
   endtask

   task automatic do_reset();
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      clear_logs();
   endtask

   task automatic chk_acc(input int idx, input logic [31:0] addr);
      if (acc_log.size() > idx) chk($sformatf("req%0d_addr", idx), acc_log[idx], addr);
      else chk($sformatf("req%0d_count", idx), 32'(acc_log.size()), 32'(idx + 1));
   endtask

   task automatic chk_del(input int idx, input logic [31:0] pc);
      if (del_log.size() > idx) begin
         chk($sformatf("del%0d_pc", idx), del_log[idx].pc, pc);
         chk($sformatf("del%0d_instr", idx), del_log[idx].instr, pc ^ XOR_K);
      end else chk($sformatf("del%0d_count", idx), 32'(del_log.size()), 32'(idx + 1));
   endtask

   task automatic chk_wrap(input int idx, input logic [31:0] pc);
      if (w_acc.size() > idx) chk($sformatf("wrap_req%0d", idx), w_acc[idx], pc);
      else chk($sformatf("wrap_req%0d_count", idx), 32'(w_acc.size()), 32'(idx + 1));
      if (w_del.size() > idx) chk($sformatf("wrap_del%0d", idx), w_del[idx], pc);
      else chk($sformatf("wrap_del%0d_count", idx), 32'(w_del.size()), 32'(idx + 1));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got t=%0t expected end before 100000", $time);
      $fatal(1);
   end

   initial begin
      clr = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0;
      id_ready = 1'b1; imem_req_ready = 1'b1; lat = 1;

      // Reset then free run with 1-cycle memory
      do_reset();
      @(negedge clk);
      chk("reset_inst_valid", inst_valid, 1'b0);
      step(14);
      for (int i = 0; i < 4; i++) begin
         chk_acc(i, 32'(i * 4));
         chk_del(i, 32'(i * 4));
      end
      chk_wrap(0, 32'hFFFF_FFF8);
      chk_wrap(1, 32'hFFFF_FFFC);
      chk_wrap(2, 32'h0000_0000);
      chk_wrap(3, 32'h0000_0004);

      // Decode stall: exactly DEPTH requests, head held
      id_ready = 1'b0;
      do_reset();
      step(10);
      chk("stall_req_count", 32'(acc_log.size()), 32'd2);
      chk_acc(0, 32'h0);
      chk_acc(1, 32'h4);
      @(negedge clk);
      chk("stall_inst_valid", inst_valid, 1'b1);
      chk("stall_pcout", PCout, 32'h0);
      chk("stall_instr", Instruction, XOR_K);
      step(1);
      id_ready = 1'b1;
      step(8);
      chk_del(0, 32'h0);
      chk_del(1, 32'h4);
      chk_del(2, 32'h8);

      // Memory not ready: request held at RESET_PC
      imem_req_ready = 1'b0;
      do_reset();
      step(4);
      @(negedge clk);
      chk("hold_req_valid", imem_req_valid, 1'b1);
      chk("hold_req_addr", imem_req_addr, 32'h0);
      chk("hold_req_count", 32'(acc_log.size()), 32'd0);
      step(1);
      imem_req_ready = 1'b1;
      step(3);
      chk_acc(0, 32'h0);

      // Redirect with two outstanding requests, latency 3
      lat = 3;
      do_reset();
      step(2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
      step(1);
      redirect_valid = 1'b0;
      step(12);
      chk_acc(0, 32'h0);
      chk_acc(1, 32'h4);
      chk_acc(2, 32'h100);
      chk_del(0, 32'h100);

      // Redirect in the same cycle as a response and a pop
      lat = 1;
      do_reset();
      step(2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
      clear_logs();
      step(1);
      redirect_valid = 1'b0;
      @(negedge clk);
      chk("flush_inst_valid", inst_valid, 1'b0);
      step(10);
      chk_acc(0, 32'h200);
      chk_del(0, 32'h200);
      chk_del(1, 32'h204);

      // Back-to-back redirects: last wins, drops accumulate
      lat = 3;
      do_reset();
      step(2);
      redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
      step(1);
      redirect_pc = 32'h0000_0407;
      step(1);
      redirect_valid = 1'b0;
      step(12);
      chk_acc(2, 32'h404);
      chk_del(0, 32'h404);
      chk_del(1, 32'h408);

      // Reset mid-operation with one queued and one outstanding
      id_ready = 1'b0;
      do_reset();
      step(4);
      clr = 1'b1;
      @(negedge clk);
      chk("clr_req_valid", imem_req_valid, 1'b0);
      step(1);
      clr = 1'b0;
      clear_logs();
      @(negedge clk);
      chk("post_clr_inst_valid", inst_valid, 1'b0);
      step(1);
      id_ready = 1'b1;
      step(10);
      chk_acc(0, 32'h0);
      chk_del(0, 32'h0);
      chk_del(1, 32'h4);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
